blink_period_monitor: RTL and testbench



---
 rtl/blink_mon_pkg.sv | 16 +
 rtl/blink_period_monitor_sync_edge_detect.sv | 89 ++++++++
 rtl/blink_period_monitor.sv | 125 ++++++++++++
 tb/tb_blink_period_monitor.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_mon_pkg.sv
// blink_mon_pkg: shared types and constants for the blink period monitor.
//   state_t        - measurement FSM state (IDLE, MEASURE)
//   CNT_W_DEFAULT  - default measurement counter / result width
//   FILTER_LEN     - samples that must agree before the filtered level moves
//                    (used only when BLINK_MON_GLITCH_FILTER_EN is defined)
package blink_mon_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned FILTER_LEN    = 3;

endpackage

// File: rtl/blink_period_monitor_sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the clk domain and
// reports its edges. Reusable by any block sampling an async input.
//
// Optional feature macro: BLINK_MON_GLITCH_FILTER_EN
//   Defined   - a FILTER_LEN-sample agreement filter follows the synchronizer;
//               the level only moves once FILTER_LEN consecutive synced
//               samples agree, so shorter pulses are ignored. Both edges gain
//               the same FILTER_LEN-1 cycles of latency.
//   Undefined - the synchronized signal feeds edge detection directly.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   async_in in   asynchronous input level
//   level    out  synchronized (optionally filtered) level
//   rise     out  one-cycle pulse on a 0->1 transition of level
//   fall     out  one-cycle pulse on a 1->0 transition of level
module sync_edge_detect
    import blink_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   hist;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

`ifdef BLINK_MON_GLITCH_FILTER_EN
    // The current synced sample plus the previous FILTER_LEN-1 samples form
    // the agreement window. The filtered level is combinational from that
    // window and otherwise holds its last value, which is exactly hist.
    logic [FILTER_LEN-2:0] samp_q;
    logic                  all_one;
    logic                  all_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '0;
        end else begin
            samp_q <= {samp_q[FILTER_LEN-3:0], sync};
        end
    end

    assign all_one  = &{samp_q, sync};
    assign all_zero = ~|{samp_q, sync};

    always_comb begin
        level = hist;
        if (all_one) begin
            level = 1'b1;
        end else if (all_zero) begin
            level = 1'b0;
        end
    end
`else
    always_comb begin
        level = sync;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= 1'b0;
        end else begin
            hist <= level;
        end
    end

    assign rise = level & ~hist;
    assign fall = ~level & hist;

endmodule

// File: rtl/blink_period_monitor.sv
// blink_period_monitor: measures the period and high time (in clk cycles) of
// an asynchronous square wave and presents each completed measurement on a
// valid/ready port. The first rise after reset or timeout only arms the
// counter; measurements start at the second rise.
//
// Optional feature macro: BLINK_MON_GLITCH_FILTER_EN (see sync_edge_detect).
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   blink_in    in   asynchronous square wave being measured
//   meas_ready  in   consumer accepts the measurement this cycle
//   meas_valid  out  measurement registers hold unconsumed data
//   meas_period out  cycles between the last two rising edges
//   meas_high   out  cycles from that rising edge to the following fall
//   locked      out  a measurement has completed since reset / timeout
//   timeout     out  one-cycle pulse when the counter saturates
//   overrun     out  sticky: a measurement was dropped (output still full)
module blink_period_monitor
    import blink_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             blink_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             locked,
    output logic             timeout,
    output logic             overrun
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] high_cap;
    logic             level_unused;
    logic             rise;
    logic             fall;
    logic             capture;
    logic             xfer;
    logic             drop;
    logic             load;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (blink_in),
        .level    (level_unused),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        capture = (state == MEASURE) && rise;
        xfer    = meas_valid && meas_ready;
        drop    = capture && meas_valid && !meas_ready;
        load    = capture && !drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            high_cap    <= '0;
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            timeout <= 1'b0;

            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        cnt   <= CNT_W'(1);
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        high_cap <= cnt;
                    end
                    // A rise on the saturating cycle still counts as a
                    // measurement; saturation only times out without one.
                    if (rise) begin
                        cnt    <= CNT_W'(1);
                        locked <= 1'b1;
                    end else if (&cnt) begin
                        cnt     <= '0;
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                meas_period <= cnt;
                meas_high   <= high_cap;
                meas_valid  <= 1'b1;
            end else if (xfer) begin
                meas_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (xfer) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_period_monitor.sv
module tb_blink_period_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        blink;
    logic        meas_ready;

    logic        meas_valid;
    logic [15:0] meas_period;
    logic [15:0] meas_high;
    logic        locked;
    logic        timeout;
    logic        overrun;

    logic        meas_valid8;
    logic [7:0]  meas_period8;
    logic [7:0]  meas_high8;
    logic        locked8;
    logic        timeout8;
    logic        overrun8;

    int checks = 0;
    int errors = 0;

    int gen_on     = 0;
    int gen_period = 10;
    int gen_high   = 5;
    int gen_phase  = 0;
    int gen_glitch = -1;

    always #5 clk = ~clk;

    blink_period_monitor #(
        .CNT_W       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .blink_in    (blink),
        .meas_ready  (meas_ready),
        .meas_valid  (meas_valid),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .locked      (locked),
        .timeout     (timeout),
        .overrun     (overrun)
    );

    blink_period_monitor #(
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .blink_in    (blink),
        .meas_ready  (meas_ready),
        .meas_valid  (meas_valid8),
        .meas_period (meas_period8),
        .meas_high   (meas_high8),
        .locked      (locked8),
        .timeout     (timeout8),
        .overrun     (overrun8)
    );

    // One clock: outputs are sampled by the caller after this returns, and
    // the wave generator advances one sample.
    task automatic step();
        @(posedge clk);
        #1;
        if (gen_on != 0) begin
            blink = (gen_phase < gen_high) ^ (gen_phase == gen_glitch);
            if (gen_phase == gen_glitch) gen_glitch = -1;
            gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
        end else begin
            blink = 1'b0;
        end
    endtask

    task automatic start_wave(input int p, input int h);
        gen_period = p;
        gen_high   = h;
        gen_phase  = 0;
        gen_glitch = -1;
        gen_on     = 1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        meas_ready = 1'b0;
        gen_on     = 0;
        blink      = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!meas_valid && n < bound);
        checks++;
        if (meas_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid got %0b want 1 within %0d cycles", meas_valid, bound);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        meas_ready = 1'b0;
        blink      = 1'b0;
        #1;
        checks++;
        if ({meas_valid, meas_period, meas_high, locked, timeout, overrun} !== '0) begin
            errors++;
            $display("FAIL reset16 got %0h want 0", {meas_valid, meas_period, meas_high, locked, timeout, overrun});
        end
        checks++;
        if ({meas_valid8, meas_period8, meas_high8, locked8, timeout8, overrun8} !== '0) begin
            errors++;
            $display("FAIL reset8 got %0h want 0", {meas_valid8, meas_period8, meas_high8, locked8, timeout8, overrun8});
        end
    endtask

    task automatic test_period_256();
        int n;
        int n2;
        do_reset();
        meas_ready = 1'b1;
        start_wave(256, 128);
        repeat (100) step();
        checks++;
        if (locked !== 1'b0 || meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL p256_prelock got locked=%0b valid=%0b want 0/0", locked, meas_valid);
        end
        wait_valid(700, n);
        n += 100;
        checks++;
        if (n < 257 || n > 262) begin
            errors++;
            $display("FAIL p256_first_latency got %0d want 257..262", n);
        end
        checks++;
        if (meas_period !== 16'd256 || meas_high !== 16'd128 || locked !== 1'b1) begin
            errors++;
            $display("FAIL p256_first got %0d/%0d locked=%0b want 256/128 locked=1", meas_period, meas_high, locked);
        end
        step();
        checks++;
        if (meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL p256_accept got valid=%0b want 0", meas_valid);
        end
        wait_valid(300, n2);
        checks++;
        if (n2 !== 255) begin
            errors++;
            $display("FAIL p256_interval got %0d want 255", n2);
        end
        checks++;
        if (meas_period !== 16'd256 || meas_high !== 16'd128) begin
            errors++;
            $display("FAIL p256_second got %0d/%0d want 256/128", meas_period, meas_high);
        end
    endtask

    task automatic test_overrun();
        int n;
        do_reset();
        start_wave(10, 3);
        repeat (40) step();
        checks++;
        if (meas_valid !== 1'b1 || meas_period !== 16'd10 || meas_high !== 16'd3 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_held got v=%0b %0d/%0d ovr=%0b want v=1 10/3 ovr=1",
                     meas_valid, meas_period, meas_high, overrun);
        end
        meas_ready = 1'b1;
        step();
        checks++;
        if (overrun !== 1'b0 || meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got ovr=%0b v=%0b want 0/0", overrun, meas_valid);
        end
        wait_valid(20, n);
        checks++;
        if (meas_period !== 16'd10 || meas_high !== 16'd3 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_next got %0d/%0d ovr=%0b want 10/3 ovr=0", meas_period, meas_high, overrun);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        start_wave(10, 3);
        wait_valid(30, n);
        gen_period = 12;
        repeat (11) step();
        checks++;
        if (meas_valid !== 1'b1 || meas_period !== 16'd10 || meas_high !== 16'd3 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stable got v=%0b %0d/%0d ovr=%0b want v=1 10/3 ovr=0",
                     meas_valid, meas_period, meas_high, overrun);
        end
        meas_ready = 1'b1;
        step();
        checks++;
        if (meas_valid !== 1'b1 || meas_period !== 16'd12 || meas_high !== 16'd3 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load got v=%0b %0d/%0d ovr=%0b want v=1 12/3 ovr=0",
                     meas_valid, meas_period, meas_high, overrun);
        end
        step();
        checks++;
        if (meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got v=%0b want 0", meas_valid);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        meas_ready = 1'b1;
        start_wave(20, 10);
        n = 0;
        do begin
            step();
            n++;
        end while (!meas_valid8 && n < 60);
        checks++;
        if (meas_valid8 !== 1'b1 || locked8 !== 1'b1 || meas_period8 !== 8'd20) begin
            errors++;
            $display("FAIL to_lock got v=%0b locked=%0b period=%0d want 1/1/20", meas_valid8, locked8, meas_period8);
        end
        gen_on = 0;
        n = 0;
        do begin
            step();
            n++;
        end while (!timeout8 && n < 400);
        checks++;
        if (timeout8 !== 1'b1 || n !== 255) begin
            errors++;
            $display("FAIL to_pulse got timeout=%0b after %0d want 1 after 255", timeout8, n);
        end
        checks++;
        if (locked8 !== 1'b0 || meas_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL to_unlock got locked=%0b v=%0b want 0/0", locked8, meas_valid8);
        end
        step();
        checks++;
        if (timeout8 !== 1'b0) begin
            errors++;
            $display("FAIL to_one_cycle got %0b want 0", timeout8);
        end
        start_wave(20, 7);
        n = 0;
        do begin
            step();
            n++;
        end while (!meas_valid8 && n < 60);
        checks++;
        if (meas_valid8 !== 1'b1 || n < 22 || n > 26) begin
            errors++;
            $display("FAIL to_relock_latency got v=%0b after %0d want 1 after 22..26", meas_valid8, n);
        end
        checks++;
        if (meas_period8 !== 8'd20 || meas_high8 !== 8'd7 || locked8 !== 1'b1) begin
            errors++;
            $display("FAIL to_relock got %0d/%0d locked=%0b want 20/7 locked=1", meas_period8, meas_high8, locked8);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        meas_ready = 1'b1;
        start_wave(30, 12);
        wait_valid(60, n);
        repeat (10) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({meas_valid, meas_period, meas_high, locked, timeout, overrun} !== '0) begin
            errors++;
            $display("FAIL rmid_async got %0h want 0", {meas_valid, meas_period, meas_high, locked, timeout, overrun});
        end
        gen_on = 0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        start_wave(30, 12);
        repeat (10) step();
        checks++;
        if (locked !== 1'b0 || meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_armed got locked=%0b v=%0b want 0/0", locked, meas_valid);
        end
        wait_valid(60, n);
        n += 10;
        checks++;
        if (n < 32 || n > 36) begin
            errors++;
            $display("FAIL rmid_latency got %0d want 32..36", n);
        end
        checks++;
        if (meas_period !== 16'd30 || meas_high !== 16'd12) begin
            errors++;
            $display("FAIL rmid_meas got %0d/%0d want 30/12", meas_period, meas_high);
        end
    endtask

    task automatic test_glitch();
        int n;
        logic [15:0] exp_period;
        do_reset();
        meas_ready = 1'b1;
        start_wave(20, 10);
        wait_valid(60, n);
        gen_glitch = 15;
`ifdef BLINK_MON_GLITCH_FILTER_EN
        exp_period = 16'd20;
`else
        exp_period = 16'd15;
`endif
        wait_valid(40, n);
        checks++;
        if (meas_period !== exp_period || meas_high !== 16'd10) begin
            errors++;
            $display("FAIL glitch got %0d/%0d want %0d/10", meas_period, meas_high, exp_period);
        end
    endtask

    initial begin
        test_reset();
        test_period_256();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
